// File: rtl/riscv_pkg.sv
// Shared RV32I definitions: opcode constants, control bundle layout and its
// all-zero bubble value.
package riscv_pkg;

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;

  localparam int REG_ADDR_W = 5;
  localparam int MEMTOREG_W = 2;
  localparam int BRANCH_W   = 2;
  localparam int UIDETECT_W = 2;
  localparam int ALUOP_W    = 3;
  localparam int FUNCT3_W   = 3;

  typedef struct packed {
    logic                  regwrite;
    logic                  alusrc;
    logic                  memread;
    logic                  memwrite;
    logic [MEMTOREG_W-1:0] memtoreg;
    logic [BRANCH_W-1:0]   branch;
    logic [UIDETECT_W-1:0] uidetect;
    logic [ALUOP_W-1:0]    aluop;
  } ctrl_t;

  localparam ctrl_t CTRL_BUBBLE = '0;

endpackage

// File: rtl/hazard_detect.sv
// Load-use hazard detection between the instruction in EX and the one in ID.
// Purely combinational; the top decides what to do with lu.
module hazard_detect
  import riscv_pkg::*;
(
  input  logic                  id_valid,
  input  logic [6:0]            opcode,
  input  logic [REG_ADDR_W-1:0] rs1_addr,
  input  logic [REG_ADDR_W-1:0] rs2_addr,
  input  logic                  ex_valid,
  input  logic                  ex_memread,
  input  logic [REG_ADDR_W-1:0] ex_rd_addr,
  output logic                  lu
);

  logic uses_rs1;
  logic uses_rs2;

  // LUI/AUIPC/JAL carry immediate bits in the rs fields, so they never match.
  always_comb begin
    uses_rs1 = 1'b0;
    uses_rs2 = 1'b0;
    case (opcode)
      OP_R, OP_STORE, OP_BRANCH: begin
        uses_rs1 = 1'b1;
        uses_rs2 = 1'b1;
      end
      OP_IMM, OP_LOAD, OP_JALR: uses_rs1 = 1'b1;
      OP_LUI, OP_AUIPC, OP_JAL: uses_rs1 = 1'b0;
      default:                  uses_rs1 = 1'b0;
    endcase
  end

  assign lu = ex_valid && ex_memread && (ex_rd_addr != '0) && id_valid &&
              ((uses_rs1 && (rs1_addr == ex_rd_addr)) ||
               (uses_rs2 && (rs2_addr == ex_rd_addr)));

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with load-use bubble insertion, flush and hold.
// Update priority per edge: reset > flush > hold > load-use > load.
module id_ex_stage
  import riscv_pkg::*;
#(
  parameter int XLEN   = 32,
  parameter int PERF_W = 16
) (
  input  logic                  i_clk,
  input  logic                  i_rst_n,
  input  logic                  i_id_valid,
  input  logic [6:0]            i_opcode,
  input  logic                  i_regwrite,
  input  logic                  i_alusrc,
  input  logic                  i_memread,
  input  logic                  i_memwrite,
  input  logic [MEMTOREG_W-1:0] i_memtoreg,
  input  logic [BRANCH_W-1:0]   i_branch,
  input  logic [UIDETECT_W-1:0] i_uidetect,
  input  logic [ALUOP_W-1:0]    i_aluop,
  input  logic [XLEN-1:0]       i_pc,
  input  logic [XLEN-1:0]       i_rs1_data,
  input  logic [XLEN-1:0]       i_rs2_data,
  input  logic [XLEN-1:0]       i_imm,
  input  logic [REG_ADDR_W-1:0] i_rs1_addr,
  input  logic [REG_ADDR_W-1:0] i_rs2_addr,
  input  logic [REG_ADDR_W-1:0] i_rd_addr,
  input  logic [FUNCT3_W-1:0]   i_funct3,
  input  logic                  i_funct7_5,
  input  logic                  i_flush,
  input  logic                  i_hold,
  output logic                  o_ex_valid,
  output logic                  o_ex_regwrite,
  output logic                  o_ex_alusrc,
  output logic                  o_ex_memread,
  output logic                  o_ex_memwrite,
  output logic [MEMTOREG_W-1:0] o_ex_memtoreg,
  output logic [BRANCH_W-1:0]   o_ex_branch,
  output logic [UIDETECT_W-1:0] o_ex_uidetect,
  output logic [ALUOP_W-1:0]    o_ex_aluop,
  output logic [XLEN-1:0]       o_ex_pc,
  output logic [XLEN-1:0]       o_ex_rs1_data,
  output logic [XLEN-1:0]       o_ex_rs2_data,
  output logic [XLEN-1:0]       o_ex_imm,
  output logic [REG_ADDR_W-1:0] o_ex_rs1_addr,
  output logic [REG_ADDR_W-1:0] o_ex_rs2_addr,
  output logic [REG_ADDR_W-1:0] o_ex_rd_addr,
  output logic [FUNCT3_W-1:0]   o_ex_funct3,
  output logic                  o_ex_funct7_5,
  output logic                  o_stall_if,
  output logic [PERF_W-1:0]     o_bubble_cnt
);

  ctrl_t id_ctrl;
  ctrl_t ex_ctrl;
  logic  lu;
  logic  take_bubble;
  logic  take_instr;
  logic  count_bubble;

  assign id_ctrl = '{regwrite: i_regwrite, alusrc: i_alusrc, memread: i_memread,
                     memwrite: i_memwrite, memtoreg: i_memtoreg, branch: i_branch,
                     uidetect: i_uidetect, aluop: i_aluop};

  hazard_detect u_hazard_detect (
    .id_valid   (i_id_valid),
    .opcode     (i_opcode),
    .rs1_addr   (i_rs1_addr),
    .rs2_addr   (i_rs2_addr),
    .ex_valid   (o_ex_valid),
    .ex_memread (ex_ctrl.memread),
    .ex_rd_addr (o_ex_rd_addr),
    .lu         (lu)
  );

  // An invalid ID slot is captured as a bubble so stale fields never reach EX.
  assign take_bubble  = i_flush | (~i_hold & (lu | ~i_id_valid));
  assign take_instr   = ~i_flush & ~i_hold & ~lu & i_id_valid;
  assign count_bubble = ~i_flush & ~i_hold & lu;
  assign o_stall_if   = (i_hold | lu) & ~i_flush;

  always_ff @(posedge i_clk) begin
    if (!i_rst_n || take_bubble) begin
      o_ex_valid    <= 1'b0;
      ex_ctrl       <= CTRL_BUBBLE;
      o_ex_pc       <= '0;
      o_ex_rs1_data <= '0;
      o_ex_rs2_data <= '0;
      o_ex_imm      <= '0;
      o_ex_rs1_addr <= '0;
      o_ex_rs2_addr <= '0;
      o_ex_rd_addr  <= '0;
      o_ex_funct3   <= '0;
      o_ex_funct7_5 <= 1'b0;
    end else if (take_instr) begin
      o_ex_valid    <= 1'b1;
      ex_ctrl       <= id_ctrl;
      o_ex_pc       <= i_pc;
      o_ex_rs1_data <= i_rs1_data;
      o_ex_rs2_data <= i_rs2_data;
      o_ex_imm      <= i_imm;
      o_ex_rs1_addr <= i_rs1_addr;
      o_ex_rs2_addr <= i_rs2_addr;
      o_ex_rd_addr  <= i_rd_addr;
      o_ex_funct3   <= i_funct3;
      o_ex_funct7_5 <= i_funct7_5;
    end
  end

  // Performance counter sticks at all-ones instead of wrapping.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      o_bubble_cnt <= '0;
    end else if (count_bubble && (o_bubble_cnt != '1)) begin
      o_bubble_cnt <= o_bubble_cnt + PERF_W'(1);
    end
  end

  assign o_ex_regwrite = ex_ctrl.regwrite;
  assign o_ex_alusrc   = ex_ctrl.alusrc;
  assign o_ex_memread  = ex_ctrl.memread;
  assign o_ex_memwrite = ex_ctrl.memwrite;
  assign o_ex_memtoreg = ex_ctrl.memtoreg;
  assign o_ex_branch   = ex_ctrl.branch;
  assign o_ex_uidetect = ex_ctrl.uidetect;
  assign o_ex_aluop    = ex_ctrl.aluop;

endmodule

// File: tb/tb_id_ex_stage.sv
// Self-checking bench for id_ex_stage: directed table, multi-cycle corner
// sequences and randomized traffic against a behavioural reference model.
module tb_id_ex_stage;
  import riscv_pkg::*;

  localparam int XLEN    = 32;
  localparam int PERF_W  = 2;
  localparam int CNT_MAX = 3;

  typedef logic [160:0] wide_t;

  typedef struct {
    logic        valid;
    logic [6:0]  opcode;
    logic        regwrite;
    logic        alusrc;
    logic        memread;
    logic        memwrite;
    logic [1:0]  memtoreg;
    logic [1:0]  branch;
    logic [1:0]  uidetect;
    logic [2:0]  aluop;
    logic [31:0] pc;
    logic [31:0] rs1_data;
    logic [31:0] rs2_data;
    logic [31:0] imm;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [4:0]  rd;
    logic [2:0]  funct3;
    logic        funct7_5;
  } id_t;

  typedef struct {
    id_t        id;
    logic       flush;
    logic       hold;
    logic       exp_stall;
    logic       exp_valid;
    logic [4:0] exp_rd;
    int         exp_cnt;
  } vec_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic              rst_n, id_valid, flush, hold;
  logic [6:0]        opcode;
  logic              regwrite, alusrc, memread, memwrite;
  logic [1:0]        memtoreg, branch, uidetect;
  logic [2:0]        aluop;
  logic [XLEN-1:0]   pc, rs1_data, rs2_data, imm;
  logic [4:0]        rs1_addr, rs2_addr, rd_addr;
  logic [2:0]        funct3;
  logic              funct7_5;
  logic              ex_valid, ex_regwrite, ex_alusrc, ex_memread, ex_memwrite;
  logic [1:0]        ex_memtoreg, ex_branch, ex_uidetect;
  logic [2:0]        ex_aluop;
  logic [XLEN-1:0]   ex_pc, ex_rs1_data, ex_rs2_data, ex_imm;
  logic [4:0]        ex_rs1_addr, ex_rs2_addr, ex_rd_addr;
  logic [2:0]        ex_funct3;
  logic              ex_funct7_5;
  logic              stall_if;
  logic [PERF_W-1:0] bubble_cnt;

  id_ex_stage #(.XLEN(XLEN), .PERF_W(PERF_W)) dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_id_valid(id_valid), .i_opcode(opcode),
    .i_regwrite(regwrite), .i_alusrc(alusrc), .i_memread(memread), .i_memwrite(memwrite),
    .i_memtoreg(memtoreg), .i_branch(branch), .i_uidetect(uidetect), .i_aluop(aluop),
    .i_pc(pc), .i_rs1_data(rs1_data), .i_rs2_data(rs2_data), .i_imm(imm),
    .i_rs1_addr(rs1_addr), .i_rs2_addr(rs2_addr), .i_rd_addr(rd_addr),
    .i_funct3(funct3), .i_funct7_5(funct7_5), .i_flush(flush), .i_hold(hold),
    .o_ex_valid(ex_valid), .o_ex_regwrite(ex_regwrite), .o_ex_alusrc(ex_alusrc),
    .o_ex_memread(ex_memread), .o_ex_memwrite(ex_memwrite), .o_ex_memtoreg(ex_memtoreg),
    .o_ex_branch(ex_branch), .o_ex_uidetect(ex_uidetect), .o_ex_aluop(ex_aluop),
    .o_ex_pc(ex_pc), .o_ex_rs1_data(ex_rs1_data), .o_ex_rs2_data(ex_rs2_data),
    .o_ex_imm(ex_imm), .o_ex_rs1_addr(ex_rs1_addr), .o_ex_rs2_addr(ex_rs2_addr),
    .o_ex_rd_addr(ex_rd_addr), .o_ex_funct3(ex_funct3), .o_ex_funct7_5(ex_funct7_5),
    .o_stall_if(stall_if), .o_bubble_cnt(bubble_cnt)
  );

  id_t m_ex;
  int  m_cnt;
  int  total  = 0;
  int  passed = 0;

  function automatic id_t bubble_id();
    id_t b;
    b = '{default: '0};
    return b;
  endfunction

  function automatic id_t mk(input logic v, input logic [6:0] op, input logic [4:0] r1,
                             input logic [4:0] r2, input logic [4:0] rd, input logic [31:0] p);
    id_t r;
    r.valid    = v;
    r.opcode   = op;
    r.regwrite = (op != OP_STORE) && (op != OP_BRANCH);
    r.alusrc   = (op != OP_R);
    r.memread  = (op == OP_LOAD);
    r.memwrite = (op == OP_STORE);
    r.memtoreg = (op == OP_LOAD) ? 2'd1 : 2'd0;
    r.branch   = (op == OP_BRANCH) ? 2'd1 : 2'd0;
    r.uidetect = {op[2], op[3]};
    r.aluop    = op[6:4];
    r.pc       = p;
    r.rs1_data = {p[15:0], 11'h0, rd};
    r.rs2_data = p ^ 32'h5a5a_0000;
    r.imm      = ~p;
    r.rs1      = r1;
    r.rs2      = r2;
    r.rd       = rd;
    r.funct3   = p[4:2];
    r.funct7_5 = rd[0];
    return r;
  endfunction

  function automatic vec_t vec(input id_t id, input logic fl, input logic ho, input logic st,
                               input logic va, input logic [4:0] rd, input int cnt);
    vec_t t;
    t.id = id; t.flush = fl; t.hold = ho;
    t.exp_stall = st; t.exp_valid = va; t.exp_rd = rd; t.exp_cnt = cnt;
    return t;
  endfunction

  function automatic wide_t pack_model(input id_t e);
    return {e.valid, e.regwrite, e.alusrc, e.memread, e.memwrite, e.memtoreg, e.branch,
            e.uidetect, e.aluop, e.pc, e.rs1_data, e.rs2_data, e.imm, e.rs1, e.rs2,
            e.rd, e.funct3, e.funct7_5};
  endfunction

  function wide_t pack_dut();
    return {ex_valid, ex_regwrite, ex_alusrc, ex_memread, ex_memwrite, ex_memtoreg,
            ex_branch, ex_uidetect, ex_aluop, ex_pc, ex_rs1_data, ex_rs2_data, ex_imm,
            ex_rs1_addr, ex_rs2_addr, ex_rd_addr, ex_funct3, ex_funct7_5};
  endfunction

  // Reference rule: a valid EX load with nonzero rd feeding a register the ID op reads.
  function automatic logic model_lu(input id_t id);
    logic r1, r2;
    r1 = id.opcode inside {OP_R, OP_IMM, OP_LOAD, OP_STORE, OP_BRANCH, OP_JALR};
    r2 = id.opcode inside {OP_R, OP_STORE, OP_BRANCH};
    return m_ex.valid && m_ex.memread && (m_ex.rd != 5'd0) && id.valid &&
           ((r1 && id.rs1 == m_ex.rd) || (r2 && id.rs2 == m_ex.rd));
  endfunction

  task automatic check(input string name, input wide_t act, input wide_t exp);
    total++;
    if (act === exp) passed++;
    else $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
  endtask

  task automatic drive(input id_t id, input logic fl, input logic ho, input logic rn);
    rst_n = rn; flush = fl; hold = ho;
    id_valid = id.valid; opcode = id.opcode;
    regwrite = id.regwrite; alusrc = id.alusrc; memread = id.memread; memwrite = id.memwrite;
    memtoreg = id.memtoreg; branch = id.branch; uidetect = id.uidetect; aluop = id.aluop;
    pc = id.pc; rs1_data = id.rs1_data; rs2_data = id.rs2_data; imm = id.imm;
    rs1_addr = id.rs1; rs2_addr = id.rs2; rd_addr = id.rd;
    funct3 = id.funct3; funct7_5 = id.funct7_5;
  endtask

  task automatic checkOutput(input string tag);
    check({tag, "_ex_valid"}, wide_t'(ex_valid), wide_t'(m_ex.valid));
    check({tag, "_ex_rd"}, wide_t'(ex_rd_addr), wide_t'(m_ex.rd));
    check({tag, "_ex_pc"}, wide_t'(ex_pc), wide_t'(m_ex.pc));
    check({tag, "_ex_bundle"}, pack_dut(), pack_model(m_ex));
    check({tag, "_bubble_cnt"}, wide_t'(bubble_cnt), wide_t'(m_cnt));
  endtask

  // One cycle: drive, check the combinational stall, clock, advance model, check EX.
  task automatic applyStimulus(input string tag, input id_t id, input logic fl, input logic ho,
                               input logic rn, output logic stall_seen);
    logic lu, exp_stall;
    drive(id, fl, ho, rn);
    #2;
    lu = model_lu(id);
    exp_stall = (ho || lu) && !fl;
    stall_seen = stall_if;
    check({tag, "_stall_if"}, wide_t'(stall_if), wide_t'(exp_stall));
    @(posedge clk);
    if (!rn) begin
      m_ex = bubble_id(); m_cnt = 0;
    end else if (fl) begin
      m_ex = bubble_id();
    end else if (ho) begin
      m_ex = m_ex;
    end else if (lu) begin
      m_ex = bubble_id();
      m_cnt = (m_cnt < CNT_MAX) ? m_cnt + 1 : CNT_MAX;
    end else if (id.valid) begin
      m_ex = id;
      m_ex.opcode = '0;
    end else begin
      m_ex = bubble_id();
    end
    #1;
    checkOutput(tag);
  endtask

  initial begin
    #200us;
    $display("[TB] FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    vec_t        tbl[$];
    logic        st;
    id_t         r;
    logic [6:0]  ops[10];

    drive(bubble_id(), 1'b0, 1'b0, 1'b0);
    repeat (2) @(posedge clk);
    #1;
    m_ex = bubble_id();
    m_cnt = 0;
    checkOutput("reset");

    tbl.push_back(vec(mk(1, OP_R,      1, 2,  3, 32'h100), 0, 0, 0, 1,  3, 0));
    tbl.push_back(vec(mk(1, OP_LOAD,   1, 0,  5, 32'h104), 0, 0, 0, 1,  5, 0));
    tbl.push_back(vec(mk(1, OP_R,      6, 5,  8, 32'h108), 0, 0, 1, 0,  0, 1));
    tbl.push_back(vec(mk(1, OP_R,      6, 5,  8, 32'h108), 0, 0, 0, 1,  8, 1));
    tbl.push_back(vec(mk(1, OP_LOAD,   2, 0,  0, 32'h10c), 0, 0, 0, 1,  0, 1));
    tbl.push_back(vec(mk(1, OP_R,      0, 0,  9, 32'h110), 0, 0, 0, 1,  9, 1));
    tbl.push_back(vec(mk(1, OP_LOAD,   3, 0,  7, 32'h114), 0, 0, 0, 1,  7, 1));
    tbl.push_back(vec(mk(1, OP_LUI,    7, 7, 10, 32'h118), 0, 0, 0, 1, 10, 1));
    tbl.push_back(vec(mk(1, OP_LOAD,   4, 0,  7, 32'h11c), 0, 0, 0, 1,  7, 1));
    tbl.push_back(vec(mk(1, OP_IMM,    1, 7, 11, 32'h120), 0, 0, 0, 1, 11, 1));
    tbl.push_back(vec(mk(1, OP_LOAD,   1, 0, 12, 32'h124), 0, 0, 0, 1, 12, 1));
    tbl.push_back(vec(mk(1, OP_STORE, 12, 12, 13, 32'h128), 1, 0, 0, 0,  0, 1));
    tbl.push_back(vec(mk(0, OP_R,      1, 2, 14, 32'h12c), 0, 0, 0, 0,  0, 1));

    foreach (tbl[i]) begin
      applyStimulus($sformatf("tbl%0d", i), tbl[i].id, tbl[i].flush, tbl[i].hold, 1'b1, st);
      check($sformatf("tbl%0d_exp_stall", i), wide_t'(st), wide_t'(tbl[i].exp_stall));
      check($sformatf("tbl%0d_exp_valid", i), wide_t'(ex_valid), wide_t'(tbl[i].exp_valid));
      check($sformatf("tbl%0d_exp_rd", i), wide_t'(ex_rd_addr), wide_t'(tbl[i].exp_rd));
      check($sformatf("tbl%0d_exp_cnt", i), wide_t'(bubble_cnt), wide_t'(tbl[i].exp_cnt));
    end

    applyStimulus("hold_pre", mk(1, OP_R, 1, 2, 20, 32'h200), 0, 0, 1, st);
    for (int k = 0; k < 3; k++) begin
      applyStimulus("hold", mk(1, OP_IMM, 5'(k), 5'(k), 5'(21 + k), 32'h300 + 32'(4 * k)),
                    0, 1, 1, st);
      check("hold_stall", wide_t'(st), wide_t'(1));
      check("hold_rd", wide_t'(ex_rd_addr), wide_t'(20));
      check("hold_pc", wide_t'(ex_pc), wide_t'(32'h200));
    end
    applyStimulus("hold_rel", mk(1, OP_R, 3, 4, 25, 32'h400), 0, 0, 1, st);
    check("hold_release_rd", wide_t'(ex_rd_addr), wide_t'(25));

    applyStimulus("holdlu_pre", mk(1, OP_LOAD, 1, 2, 5, 32'h404), 0, 0, 1, st);
    applyStimulus("holdlu", mk(1, OP_R, 5, 1, 26, 32'h408), 0, 1, 1, st);
    check("holdlu_stall", wide_t'(st), wide_t'(1));
    check("holdlu_cnt", wide_t'(bubble_cnt), wide_t'(1));
    check("holdlu_rd", wide_t'(ex_rd_addr), wide_t'(5));
    applyStimulus("holdlu_rel", mk(1, OP_R, 5, 1, 26, 32'h408), 0, 0, 1, st);
    check("holdlu_rel_stall", wide_t'(st), wide_t'(1));
    check("holdlu_rel_cnt", wide_t'(bubble_cnt), wide_t'(2));
    applyStimulus("holdlu_go", mk(1, OP_R, 5, 1, 26, 32'h408), 0, 0, 1, st);
    check("holdlu_go_rd", wide_t'(ex_rd_addr), wide_t'(26));

    applyStimulus("rst_pre", mk(1, OP_LOAD, 1, 2, 5, 32'h500), 0, 0, 1, st);
    applyStimulus("rst_mid", mk(1, OP_R, 5, 5, 27, 32'h504), 0, 0, 0, st);
    check("rst_mid_stall", wide_t'(st), wide_t'(1));
    check("rst_valid", wide_t'(ex_valid), wide_t'(0));
    check("rst_cnt", wide_t'(bubble_cnt), wide_t'(0));
    applyStimulus("rst_after", mk(1, OP_R, 5, 5, 27, 32'h504), 0, 0, 1, st);
    check("rst_after_stall", wide_t'(st), wide_t'(0));
    check("rst_after_rd", wide_t'(ex_rd_addr), wide_t'(27));

    for (int k = 0; k < 5; k++) begin
      applyStimulus("sat_ld", mk(1, OP_LOAD, 1, 2, 5, 32'h600), 0, 0, 1, st);
      applyStimulus("sat_use", mk(1, OP_R, 5, 3, 6, 32'h604), 0, 0, 1, st);
      applyStimulus("sat_go", mk(1, OP_R, 5, 3, 6, 32'h604), 0, 0, 1, st);
      if (k == 3) check("sat_cnt4", wide_t'(bubble_cnt), wide_t'(3));
    end
    check("sat_cnt5", wide_t'(bubble_cnt), wide_t'(3));

    ops = '{OP_R, OP_IMM, OP_LOAD, OP_STORE, OP_BRANCH, OP_LUI, OP_AUIPC, OP_JAL, OP_JALR, 7'h7f};
    for (int n = 0; n < 400; n++) begin
      r.valid    = ($urandom_range(3, 0) != 0);
      r.opcode   = ($urandom_range(1, 0) == 1) ? OP_LOAD : ops[$urandom_range(9, 0)];
      r.regwrite = 1'($urandom);
      r.alusrc   = 1'($urandom);
      r.memread  = (r.opcode == OP_LOAD) ? 1'b1 : 1'($urandom);
      r.memwrite = 1'($urandom);
      r.memtoreg = 2'($urandom);
      r.branch   = 2'($urandom);
      r.uidetect = 2'($urandom);
      r.aluop    = 3'($urandom);
      r.pc       = $urandom;
      r.rs1_data = $urandom;
      r.rs2_data = $urandom;
      r.imm      = $urandom;
      r.rs1      = 5'($urandom_range(3, 0));
      r.rs2      = 5'($urandom_range(3, 0));
      r.rd       = 5'($urandom_range(3, 0));
      r.funct3   = 3'($urandom);
      r.funct7_5 = 1'($urandom);
      applyStimulus("rnd", r, ($urandom_range(9, 0) == 0), ($urandom_range(7, 0) == 0),
                    ($urandom_range(49, 0) != 0), st);
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/id_ex_stage.md
# id_ex_stage

ID/EX pipeline stage of the 5-stage RV32I core. It registers the decoded control bundle from the control unit, together with register-file read data, the immediate, the PC and the register indices, into the EX stage. It also detects load-use hazards, inserts bubbles, and applies branch/jump flushes and downstream holds. It sits directly downstream of the control unit and register file, and directly upstream of the ALU/branch unit.

## Interface
- `XLEN`, default 32: data/PC width.
- `PERF_W`, default 16: width of the saturating bubble counter.
- `i_clk` in 1: clock, rising edge.
- `i_rst_n` in 1: one clock; reset is synchronous and active-low.
- `i_id_valid` in 1: decode stage holds a real instruction.
- `i_opcode` in 7: decoded instruction opcode, used for rs1/rs2 usage.
- `i_regwrite`, `i_alusrc`, `i_memread`, `i_memwrite` in 1 each: control-unit bits.
- `i_memtoreg`, `i_branch`, `i_uidetect` in 2 each: control-unit fields.
- `i_aluop` in 3: control-unit ALU class.
- `i_pc`, `i_rs1_data`, `i_rs2_data`, `i_imm` in XLEN each.
- `i_rs1_addr`, `i_rs2_addr`, `i_rd_addr` in 5 each.
- `i_funct3` in 3; `i_funct7_5` in 1.
- `i_flush` in 1: taken branch/jump redirect resolved in EX.
- `i_hold` in 1: downstream stall (data memory wait).
- `o_ex_*` out: registered copy of every `i_*` field above, excluding `i_opcode`, `i_flush` and `i_hold`. Each has the same width as its input.
- `o_ex_valid` out 1: EX holds a real instruction.
- `o_stall_if` out 1: freeze PC and IF/ID this cycle (combinational).
- `o_bubble_cnt` out PERF_W: number of load-use bubbles inserted, saturating.

## Operation
- The register update priority on each rising edge is: reset > flush > hold > load-use > load.
- **Reset** (`i_rst_n`=0): all `o_ex_*` fields are 0, `o_ex_valid`=0 and `o_bubble_cnt`=0.
- **Flush** (`i_flush`=1): load a bubble, i.e. all `o_ex_*` fields 0 and `o_ex_valid`=0. `o_stall_if`=0, because the redirect overrides any stall.
- **Hold** (`i_hold`=1, no flush): all registers retain their value and `o_stall_if`=1.
- **Load-use condition** `lu` is true when all of the following hold:
  - `o_ex_valid` and `o_ex_memread` are both set;
  - `o_ex_rd_addr` is not 0;
  - `i_id_valid` is set;
  - either (`uses_rs1` and `i_rs1_addr`==`o_ex_rd_addr`) or (`uses_rs2` and `i_rs2_addr`==`o_ex_rd_addr`).
- `uses_rs1` is true for the R, OP-IMM, LOAD, STORE, BRANCH and JALR opcodes. It is false for LUI, AUIPC, JAL and unknown opcodes.
- `uses_rs2` is true for the R, STORE and BRANCH opcodes.
- **Load-use action** (`lu`, no flush, no hold): load a bubble, assert `o_stall_if`=1, and increment `o_bubble_cnt`. The counter saturates at all-ones.
- **Load** (none of the above): capture all inputs and set `o_ex_valid` to `i_id_valid`.
- If `i_id_valid`=0 during a load, capture a bubble (all fields 0), not the stale data.
- `o_stall_if` = (`i_hold` or `lu`) and not `i_flush`.

## Timing
- Latency is 1 cycle from ID inputs to the `o_ex_*` outputs.
- `o_stall_if` is combinational from the current EX registers and the ID inputs. It has no dependency on `i_clk` within the cycle.
- A load-use hazard produces exactly one bubble. On the next cycle `o_ex_valid`=0, so `lu`=0 and the held ID instruction loads.
- Hold together with `lu`: hold wins. There is no bubble, the counter is not incremented, and `lu` is re-evaluated after the hold releases.
- Flush together with `lu` or hold: flush wins and the counter is not incremented.
- Reset asserted mid-stall clears EX on that edge. `o_stall_if` follows from the cleared registers on the next cycle.
- A destination of x0 never stalls.

## Structure
- A shared package `riscv_pkg` holds:
  - the opcode constants (OP_R=0110011, OP_IMM=0010011, OP_LOAD=0000011, OP_STORE=0100011, OP_BRANCH=1100011, OP_LUI=0110111, OP_AUIPC=0010111, OP_JAL=1101111, OP_JALR=1100111);
  - the control bundle widths;
  - the bubble (all-zero) constant.
- One combinational sub-module, `hazard_detect`, computes `uses_rs1`, `uses_rs2` and `lu`. The `id_ex_stage` top holds the registers, the priority logic and the counter.

## Test plan
- **Plain load:** `i_id_valid`=1, OP_R, rs1=1, rs2=2, rd=3, `i_pc`=0x100. One cycle later `o_ex_valid`=1, `o_ex_rd_addr`=3, `o_ex_pc`=0x100 and `o_ex_regwrite`=1. `o_stall_if`=0 throughout.
- **Load-use:** EX holds a LOAD with rd=5; ID presents OP_R with rs2=5. `o_stall_if`=1 for exactly one cycle, followed by one EX bubble (`o_ex_valid`=0, `o_ex_memread`=0), then the R-type instruction. `o_bubble_cnt` goes 0 to 1.
- **No false stall:**
  - EX LOAD with rd=0 and ID rs1=0: no stall.
  - EX LOAD with rd=7 and ID LUI whose rs1 field is 7: no stall.
  - EX LOAD with rd=7 and ID OP_IMM whose rs2 field is 7: no stall.
- **Flush priority:** `i_flush`=1 in the same cycle as a load-use hazard. `o_stall_if`=0, EX becomes a bubble, and `o_bubble_cnt` is unchanged.
- **Hold:** `i_hold`=1 for 3 cycles with changing ID inputs. The `o_ex_*` outputs stay constant and `o_stall_if`=1; after release the next ID instruction loads.
- **Reset and saturation:** `i_rst_n`=0 mid-stream clears all outputs on the next edge. With `PERF_W`=2, 4 bubbles leave `o_bubble_cnt`=3.
